// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch and PC-sequencing stage of the single-cycle MIPS core. Holds the PC,
// fetches the word at PC over a request/ready handshake, presents it to decode
// until execute reports completion, then selects the next PC from the
// sequential, branch, jump and jump-register candidates.
//
// Optional feature macro: RETIRE_CNT_EN (adds the RETIRE_CNT output).
//
// Ports:
//   CLK, RST        clock (rising edge), synchronous active-high reset
//   IMEM_REQ        fetch request to instruction memory (registered)
//   IMEM_ADDR       fetch byte address, equal to PC (registered)
//   IMEM_RDY        memory ready; IMEM_RDATA valid while IMEM_REQ=1
//   IMEM_RDATA      fetched instruction word
//   INSTR           registered instruction presented to decode
//   INSTR_VALID     INSTR valid and stable
//   PC              address of INSTR
//   PC_PLUS4        PC+4 (combinational from the PC register)
//   EXEC_DONE       execute finished INSTR; redirect inputs valid
//   BRANCH_TAKEN    conditional branch taken
//   SIGN_IMM        sign-extended branch offset (words)
//   JUMP            J/JAL, target from INSTR[25:0]
//   JR, JR_TARGET   jump-register and its target
//   MISALIGN        sticky: a JR target had nonzero bits [1:0]
//   RETIRE_CNT      retired-instruction count (only with RETIRE_CNT_EN)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = 32'h0040_0000
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              IMEM_REQ,
  output logic [DATA_W-1:0] IMEM_ADDR,
  input  logic              IMEM_RDY,
  input  logic [DATA_W-1:0] IMEM_RDATA,
  output logic [DATA_W-1:0] INSTR,
  output logic              INSTR_VALID,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] PC_PLUS4,
  input  logic              EXEC_DONE,
  input  logic              BRANCH_TAKEN,
  input  logic [DATA_W-1:0] SIGN_IMM,
  input  logic              JUMP,
  input  logic              JR,
  input  logic [DATA_W-1:0] JR_TARGET,
`ifdef RETIRE_CNT_EN
  output logic              MISALIGN,
  output logic [DATA_W-1:0] RETIRE_CNT
`else
  output logic              MISALIGN
`endif
);

  // state | meaning
  // IDLE  | one cycle after reset release, no request
  // FETCH | request outstanding at PC, waiting for IMEM_RDY
  // ISSUE | INSTR valid for decode, waiting for EXEC_DONE
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic              mis_q, mis_d;

  logic [DATA_W-1:0] pc_plus4;
  logic [DATA_W-1:0] imm_shifted;
  logic [DATA_W-1:0] next_pc;
  logic              retire;

  assign pc_plus4    = pc_q + DATA_W'(4);
  assign imm_shifted = SIGN_IMM << 2;

  // Redirect priority: JR > JUMP > taken branch > sequential.
  always_comb begin
    next_pc = pc_plus4;
    if (JR) begin
      next_pc = {JR_TARGET[DATA_W-1:2], 2'b00};
    end else if (JUMP) begin
      next_pc = {pc_plus4[DATA_W-1:28], instr_q[25:0], 2'b00};
    end else if (BRANCH_TAKEN) begin
      next_pc = pc_plus4 + imm_shifted;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    req_d   = req_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    retire  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        req_d   = 1'b1;
      end
      S_FETCH: begin
        if (IMEM_RDY) begin
          instr_d = IMEM_RDATA;
          req_d   = 1'b0;
          valid_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (EXEC_DONE) begin
          retire  = 1'b1;
          pc_d    = next_pc;
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = S_FETCH;
          if (JR && (JR_TARGET[1:0] != 2'b00)) begin
            mis_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Reset has priority, so an IMEM_RDY in the reset cycle is discarded.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

`ifdef RETIRE_CNT_EN
  logic [DATA_W-1:0] retire_cnt_q, retire_cnt_d;

  assign retire_cnt_d = retire ? retire_cnt_q + DATA_W'(1) : retire_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign RETIRE_CNT = retire_cnt_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

  // The fetch address is the PC register itself; it cannot move while a
  // request is pending because the PC only changes in ISSUE.
  assign IMEM_REQ    = req_q;
  assign IMEM_ADDR   = pc_q;
  assign INSTR       = instr_q;
  assign INSTR_VALID = valid_q;
  assign PC          = pc_q;
  assign PC_PLUS4    = pc_plus4;
  assign MISALIGN    = mis_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        CLK;
  logic        RST;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_RDY;
  logic [31:0] IMEM_RDATA;
  logic [31:0] INSTR;
  logic        INSTR_VALID;
  logic [31:0] PC;
  logic [31:0] PC_PLUS4;
  logic        EXEC_DONE;
  logic        BRANCH_TAKEN;
  logic [31:0] SIGN_IMM;
  logic        JUMP;
  logic        JR;
  logic [31:0] JR_TARGET;
  logic        MISALIGN;
`ifdef RETIRE_CNT_EN
  logic [31:0] RETIRE_CNT;
`endif

  int n_cmp = 0;
  int n_err = 0;

  instr_fetch_unit #(
    .DATA_W   (32),
    .RESET_PC (32'h0040_0000)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .IMEM_REQ     (IMEM_REQ),
    .IMEM_ADDR    (IMEM_ADDR),
    .IMEM_RDY     (IMEM_RDY),
    .IMEM_RDATA   (IMEM_RDATA),
    .INSTR        (INSTR),
    .INSTR_VALID  (INSTR_VALID),
    .PC           (PC),
    .PC_PLUS4     (PC_PLUS4),
    .EXEC_DONE    (EXEC_DONE),
    .BRANCH_TAKEN (BRANCH_TAKEN),
    .SIGN_IMM     (SIGN_IMM),
    .JUMP         (JUMP),
    .JR           (JR),
    .JR_TARGET    (JR_TARGET),
`ifdef RETIRE_CNT_EN
    .MISALIGN     (MISALIGN),
    .RETIRE_CNT   (RETIRE_CNT)
`else
    .MISALIGN     (MISALIGN)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; IMEM_RDY = 1'b0; IMEM_RDATA = '0; EXEC_DONE = 1'b0;
    BRANCH_TAKEN = 1'b0; SIGN_IMM = '0; JUMP = 1'b0; JR = 1'b0; JR_TARGET = '0;
    tick(); tick();

    // reset state
    chk("rst_req",   32'(IMEM_REQ), 32'd0);
    chk("rst_pc",    PC, 32'h0040_0000);
    chk("rst_addr",  IMEM_ADDR, 32'h0040_0000);
    chk("rst_instr", INSTR, 32'h0);
    chk("rst_valid", 32'(INSTR_VALID), 32'd0);
    chk("rst_mis",   32'(MISALIGN), 32'd0);
    chk("rst_pc4",   PC_PLUS4, 32'h0040_0004);
`ifdef RETIRE_CNT_EN
    chk("rst_ret",   RETIRE_CNT, 32'd0);
`endif

    // IDLE for one cycle, then FETCH
    RST = 1'b0;
    tick();
    chk("seq0_req",   32'(IMEM_REQ), 32'd1);
    chk("seq0_addr",  IMEM_ADDR, 32'h0040_0000);
    chk("seq0_valid", 32'(INSTR_VALID), 32'd0);

    // sequential fetches, RDY and EXEC_DONE held high
    IMEM_RDY = 1'b1; EXEC_DONE = 1'b1; IMEM_RDATA = 32'h1111_1111;
    tick();
    chk("seq0_iss_valid", 32'(INSTR_VALID), 32'd1);
    chk("seq0_iss_instr", INSTR, 32'h1111_1111);
    chk("seq0_iss_req",   32'(IMEM_REQ), 32'd0);
    chk("seq0_iss_pc",    PC, 32'h0040_0000);
    IMEM_RDATA = 32'h2222_2222;
    tick();
    chk("seq1_addr",  IMEM_ADDR, 32'h0040_0004);
    chk("seq1_req",   32'(IMEM_REQ), 32'd1);
    chk("seq1_valid", 32'(INSTR_VALID), 32'd0);
    tick();
    chk("seq1_iss_valid", 32'(INSTR_VALID), 32'd1);
    chk("seq1_iss_instr", INSTR, 32'h2222_2222);
    chk("seq1_iss_pc",    PC, 32'h0040_0004);
    tick();
    chk("seq2_addr", IMEM_ADDR, 32'h0040_0008);
    chk("seq2_req",  32'(IMEM_REQ), 32'd1);

    // wait states; EXEC_DONE and a branch are present but must be ignored
    IMEM_RDY = 1'b0; BRANCH_TAKEN = 1'b1; SIGN_IMM = 32'h0000_0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_req",   32'(IMEM_REQ), 32'd1);
      chk("wait_addr",  IMEM_ADDR, 32'h0040_0008);
      chk("wait_valid", 32'(INSTR_VALID), 32'd0);
    end
    IMEM_RDY = 1'b1; IMEM_RDATA = 32'h3333_3333; EXEC_DONE = 1'b0;
    BRANCH_TAKEN = 1'b0; SIGN_IMM = '0;
    tick();
    chk("wait_iss_valid", 32'(INSTR_VALID), 32'd1);
    chk("wait_iss_instr", INSTR, 32'h3333_3333);

    // hold in ISSUE while EXEC_DONE is low; RDATA changes must not leak
    IMEM_RDATA = 32'h5555_5555;
    tick();
    chk("hold_valid", 32'(INSTR_VALID), 32'd1);
    chk("hold_instr", INSTR, 32'h3333_3333);
    chk("hold_pc",    PC, 32'h0040_0008);
    chk("hold_req",   32'(IMEM_REQ), 32'd0);

    // step to PC 0x00400010
    EXEC_DONE = 1'b1; IMEM_RDATA = 32'h6666_6666;
    tick(); tick(); tick();
    chk("seq4_addr", IMEM_ADDR, 32'h0040_0010);
    tick();
    chk("br_pc",  PC, 32'h0040_0010);
    chk("br_pc4", PC_PLUS4, 32'h0040_0014);

    // backward branch: 0x00400014 + (-4<<2)
    BRANCH_TAKEN = 1'b1; SIGN_IMM = 32'hFFFF_FFFC;
    tick();
    chk("br_addr", IMEM_ADDR, 32'h0040_0004);

    // aligned JR back to the reset vector
    BRANCH_TAKEN = 1'b0; SIGN_IMM = '0; JR = 1'b1; JR_TARGET = 32'h0040_0000;
    tick(); tick();
    chk("jr_addr", IMEM_ADDR, 32'h0040_0000);
    chk("jr_mis",  32'(MISALIGN), 32'd0);

    // jump beats a taken branch
    JR = 1'b0; IMEM_RDATA = 32'h0810_0008; JUMP = 1'b1;
    BRANCH_TAKEN = 1'b1; SIGN_IMM = 32'h0000_0040;
    tick();
    chk("j_instr", INSTR, 32'h0810_0008);
    tick();
    chk("j_addr", IMEM_ADDR, 32'h0040_0020);

    // JR beats jump and branch; misaligned target
    JR = 1'b1; JR_TARGET = 32'h0040_0031; IMEM_RDATA = 32'h4444_4444;
    tick(); tick();
    chk("pri_addr", IMEM_ADDR, 32'h0040_0030);
    chk("pri_mis",  32'(MISALIGN), 32'd1);

    // MISALIGN stays set through a sequential instruction
    JR = 1'b0; JUMP = 1'b0; BRANCH_TAKEN = 1'b0; SIGN_IMM = '0;
    tick(); tick();
    chk("sticky_addr", IMEM_ADDR, 32'h0040_0034);
    chk("sticky_mis",  32'(MISALIGN), 32'd1);

    // jump to the top of the address space, then wrap
    JR = 1'b1; JR_TARGET = 32'hFFFF_FFFC;
    tick(); tick();
    chk("top_addr", IMEM_ADDR, 32'hFFFF_FFFC);
    chk("top_pc4",  PC_PLUS4, 32'h0000_0000);
    JR = 1'b0;
    tick(); tick();
    chk("wrap_addr", IMEM_ADDR, 32'h0000_0000);
    chk("wrap_req",  32'(IMEM_REQ), 32'd1);
    chk("wrap_mis",  32'(MISALIGN), 32'd1);
`ifdef RETIRE_CNT_EN
    chk("ret_count", RETIRE_CNT, 32'd11);
`endif

    // reset during a pending fetch
    IMEM_RDY = 1'b0; RST = 1'b1;
    tick();
    chk("mrst_req",   32'(IMEM_REQ), 32'd0);
    chk("mrst_pc",    PC, 32'h0040_0000);
    chk("mrst_addr",  IMEM_ADDR, 32'h0040_0000);
    chk("mrst_valid", 32'(INSTR_VALID), 32'd0);
    chk("mrst_mis",   32'(MISALIGN), 32'd0);
`ifdef RETIRE_CNT_EN
    chk("mrst_ret",   RETIRE_CNT, 32'd0);
`endif

    // IMEM_RDY coincident with reset is discarded
    RST = 1'b0;
    tick();
    chk("re_req", 32'(IMEM_REQ), 32'd1);
    IMEM_RDY = 1'b1; IMEM_RDATA = 32'h7777_7777; RST = 1'b1;
    tick();
    chk("crst_valid", 32'(INSTR_VALID), 32'd0);
    chk("crst_instr", INSTR, 32'h0);
    chk("crst_req",   32'(IMEM_REQ), 32'd0);
    RST = 1'b0; IMEM_RDY = 1'b0; EXEC_DONE = 1'b0;
    tick();
    chk("post_req",  32'(IMEM_REQ), 32'd1);
    chk("post_addr", IMEM_ADDR, 32'h0040_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
